// File: rtl/pu_or1k_bp_pkg.sv
// Shared types and helpers for the OR1K bimodal branch predictor table controller.
package pu_or1k_bp_pkg;

    localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
    localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
    localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
    localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (cnt == STRONGLY_TAKEN) ? cnt : cnt + 2'd1;
        end else begin
            res = (cnt == STRONGLY_NOT_TAKEN) ? cnt : cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pu_or1k_bp_counter_ram.sv
// Single-port counter RAM: synchronous 1-cycle read, write enable, contents not reset.
module pu_or1k_bp_counter_ram #(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] addr,
    input  logic [1:0]             wdata,
    output logic [1:0]             rdata
);

    localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;

    logic [1:0] mem [ENTRIES];

    // Read data only changes on a read, so it holds the last lookup result.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/pu_or1k_branch_predictor_table_ctrl.sv
// Bimodal predictor table controller: init sweep, update queue, lookup/drain arbitration.
// Optional youngest-entry queue bypass for lookups: define PU_OR1K_BP_BYPASS_EN.
module pu_or1k_branch_predictor_table_ctrl
    import pu_or1k_bp_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned UPDQ_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lookup_valid_i,
    output logic                   lookup_ready_o,
    input  logic [INDEX_WIDTH-1:0] lookup_index_i,
    input  logic                   lookup_op_bf_i,
    input  logic                   lookup_op_bnf_i,
    output logic [1:0]             lookup_cnt_o,
    output logic                   predicted_flag_o,
    input  logic                   upd_valid_i,
    output logic                   upd_ready_o,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic [1:0]             upd_cnt_i,
    input  logic                   upd_taken_i,
    output logic                   busy_o
);

    localparam int unsigned QPW = (UPDQ_DEPTH > 1) ? $clog2(UPDQ_DEPTH) : 1;
    localparam int unsigned QCW = $clog2(UPDQ_DEPTH + 1);

    bp_state_e              state_q;
    logic [INDEX_WIDTH-1:0] init_ptr_q;
    logic                   busy_q, upd_ready_q;
    logic [INDEX_WIDTH-1:0] q_idx [UPDQ_DEPTH];
    logic [1:0]             q_cnt [UPDQ_DEPTH];
    logic [QPW-1:0]         head_q, tail_q;
    logic [QCW-1:0]         count_q, count_next;
    logic                   q_full, q_empty, lookup_fire, upd_fire, drain;
    logic                   from_ram_q, bf_q, bnf_q;
    logic [1:0]             cnt_q;
    logic                   byp_hit;
    logic [1:0]             byp_cnt;
    logic                   ram_en, ram_we;
    logic [INDEX_WIDTH-1:0] ram_addr;
    logic [1:0]             ram_wdata, ram_rdata;

    assign q_full         = (count_q == QCW'(UPDQ_DEPTH));
    assign q_empty        = (count_q == '0);
    assign lookup_ready_o = (state_q == ST_INIT) || !q_full;
    assign lookup_fire    = lookup_valid_i && lookup_ready_o;
    assign upd_fire       = upd_valid_i && upd_ready_q;
    // A full queue pre-empts lookups; otherwise lookups win and drains use idle slots.
    assign drain          = (state_q == ST_RUN) && !q_empty && (q_full || !lookup_valid_i);

    always_comb begin
        count_next = count_q;
        if (upd_fire && !drain) begin
            count_next = count_q + QCW'(1);
        end else if (!upd_fire && drain) begin
            count_next = count_q - QCW'(1);
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = lookup_index_i;
        ram_wdata = WEAKLY_TAKEN;
        if (state_q == ST_INIT) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = init_ptr_q;
        end else if (drain) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = q_idx[head_q];
            ram_wdata = q_cnt[head_q];
        end else if (lookup_fire) begin
            ram_en = 1'b1;
        end
    end

`ifdef PU_OR1K_BP_BYPASS_EN
    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        byp_hit = 1'b0;
        byp_cnt = WEAKLY_TAKEN;
        for (int unsigned k = 0; k < UPDQ_DEPTH; k++) begin
            if ((QCW'(k) < count_q) && (q_idx[QPW'(head_q + QPW'(k))] == lookup_index_i)) begin
                byp_hit = 1'b1;
                byp_cnt = q_cnt[QPW'(head_q + QPW'(k))];
            end
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_cnt = WEAKLY_TAKEN;
`endif

    always_ff @(posedge clk) begin
        if (upd_fire) begin
            q_idx[tail_q] <= upd_index_i;
            q_cnt[tail_q] <= sat_next(upd_cnt_i, upd_taken_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            busy_q      <= 1'b1;
            upd_ready_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            from_ram_q  <= 1'b0;
            cnt_q       <= WEAKLY_TAKEN;
            bf_q        <= 1'b0;
            bnf_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + INDEX_WIDTH'(1);
                    if (&init_ptr_q) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b0;
                        upd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    upd_ready_q <= (count_next != QCW'(UPDQ_DEPTH));
                    count_q     <= count_next;
                    if (upd_fire) tail_q <= tail_q + QPW'(1);
                    if (drain)    head_q <= head_q + QPW'(1);
                end
            endcase

            if (lookup_fire) begin
                bf_q  <= lookup_op_bf_i;
                bnf_q <= lookup_op_bnf_i;
                if (state_q == ST_INIT) begin
                    cnt_q      <= WEAKLY_TAKEN;
                    from_ram_q <= 1'b0;
                end else if (byp_hit) begin
                    cnt_q      <= byp_cnt;
                    from_ram_q <= 1'b0;
                end else begin
                    from_ram_q <= 1'b1;
                end
            end
        end
    end

    assign upd_ready_o      = upd_ready_q;
    assign busy_o           = busy_q;
    assign lookup_cnt_o     = from_ram_q ? ram_rdata : cnt_q;
    assign predicted_flag_o = (lookup_cnt_o[1] && bf_q) || (!lookup_cnt_o[1] && bnf_q);

    pu_or1k_bp_counter_ram #(
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_pu_or1k_branch_predictor_table_ctrl.sv
// Randomized + directed bench for pu_or1k_branch_predictor_table_ctrl against a queue/array model.
module tb_pu_or1k_branch_predictor_table_ctrl;

    localparam int IW = 6;
    localparam int D  = 2;
    localparam int N  = 1 << IW;
`ifdef PU_OR1K_BP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lookup_valid_i, lookup_ready_o, lookup_op_bf_i, lookup_op_bnf_i;
    logic [IW-1:0] lookup_index_i, upd_index_i;
    logic [1:0]    lookup_cnt_o, upd_cnt_i;
    logic          predicted_flag_o, upd_valid_i, upd_ready_o, upd_taken_i, busy_o;

    pu_or1k_branch_predictor_table_ctrl #(.INDEX_WIDTH(IW), .UPDQ_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
        .lookup_index_i(lookup_index_i), .lookup_op_bf_i(lookup_op_bf_i),
        .lookup_op_bnf_i(lookup_op_bnf_i), .lookup_cnt_o(lookup_cnt_o),
        .predicted_flag_o(predicted_flag_o), .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_o), .upd_index_i(upd_index_i), .upd_cnt_i(upd_cnt_i),
        .upd_taken_i(upd_taken_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    int busy_seen = 0, lrdy_low = 0;

    // Reference model: table contents, FIFO of pending writes, last lookup result.
    bit m_init;
    int m_ptr, m_cnt;
    bit m_bf, m_bnf;
    int m_tbl [N];
    int mq_idx [$];
    int mq_val [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        m_init = 1'b1; m_ptr = 0; m_cnt = 2; m_bf = 1'b0; m_bnf = 1'b0;
        mq_idx.delete(); mq_val.delete();
    endtask

    task automatic model_drain();
        m_tbl[mq_idx[0]] = mq_val[0];
        void'(mq_idx.pop_front());
        void'(mq_val.pop_front());
    endtask

    task automatic check_outputs();
        int  n = mq_idx.size();
        bit  f = ((m_cnt >= 2) && m_bf) || ((m_cnt < 2) && m_bnf);
        chk("busy", 32'(busy_o), 32'(m_init));
        chk("upd_ready", 32'(upd_ready_o), 32'(!m_init && n < D));
        chk("lookup_ready", 32'(lookup_ready_o), 32'(m_init || n < D));
        chk("lookup_cnt", 32'(lookup_cnt_o), 32'(m_cnt));
        chk("pred_flag", 32'(predicted_flag_o), 32'(f));
    endtask

    task automatic model_step(input bit lv, input int li, input bit bf, input bit bnf,
                              input bit uv, input int ui, input int uc, input bit ut);
        int n;
        if (m_init) begin
            if (lv) begin m_cnt = 2; m_bf = bf; m_bnf = bnf; end
            m_tbl[m_ptr] = 2;
            m_ptr++;
            if (m_ptr == N) m_init = 1'b0;
        end else begin
            n = mq_idx.size();
            if (n == D) begin
                model_drain();
            end else if (lv) begin
                m_bf = bf; m_bnf = bnf;
                m_cnt = m_tbl[li];
                if (BYP) for (int i = 0; i < n; i++) if (mq_idx[i] == li) m_cnt = mq_val[i];
            end else if (n > 0) begin
                model_drain();
            end
            if (uv && n < D) begin
                mq_idx.push_back(ui);
                mq_val.push_back(sat(uc, ut));
            end
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at the next posedge.
    task automatic cycle(input bit lv, input int li, input bit bf, input bit bnf,
                         input bit uv, input int ui, input int uc, input bit ut);
        lookup_valid_i = lv; lookup_index_i = IW'(li);
        lookup_op_bf_i = bf; lookup_op_bnf_i = bnf;
        upd_valid_i = uv; upd_index_i = IW'(ui); upd_cnt_i = 2'(uc); upd_taken_i = ut;
        @(negedge clk);
        if (busy_o === 1'b1) busy_seen++;
        if (lookup_ready_o === 1'b0) lrdy_low++;
        check_outputs();
        model_step(lv, li, bf, bnf, uv, ui, uc, ut);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lookup_valid_i = 0; upd_valid_i = 0;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        busy_seen = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        lookup_valid_i = 0; lookup_index_i = '0; lookup_op_bf_i = 0; lookup_op_bnf_i = 0;
        upd_valid_i = 0; upd_index_i = '0; upd_cnt_i = '0; upd_taken_i = 0;
        for (int i = 0; i < N; i++) m_tbl[i] = -1;
        #1;
        do_reset();

        // Init sweep length and contents.
        idle(70);
        chk("busy_len", 32'(busy_seen), 32'd64);
        for (int i = 0; i < N; i++) cycle(1, i, 0, 1, 0, 0, 0, 0);
        idle(1);
        chk("init_last_cnt", 32'(lookup_cnt_o), 32'd2);

        // Three taken updates walk index 5 up to strongly taken.
        cycle(0, 0, 0, 0, 1, 5, 0, 1);
        cycle(0, 0, 0, 0, 1, 5, 1, 1);
        cycle(0, 0, 0, 0, 1, 5, 2, 1);
        idle(3);
        cycle(1, 5, 1, 0, 0, 0, 0, 0);
        idle(1);
        chk("idx5_cnt", 32'(lookup_cnt_o), 32'd3);
        chk("idx5_flag", 32'(predicted_flag_o), 32'd1);

        // Continuous lookups while two updates fill the queue.
        lrdy_low = 0;
        cycle(1, 1, 0, 0, 1, 20, 1, 0);
        cycle(1, 2, 0, 0, 1, 21, 3, 0);
        for (int i = 0; i < 5; i++) cycle(1, 3, 1, 0, 0, 0, 0, 0);
        chk("lrdy_low_cycles", 32'(lrdy_low), 32'd1);
        chk("upd_ready_back", 32'(upd_ready_o), 32'd1);
        idle(4);

        // Lookup hits a pending update to index 9.
        cycle(1, 9, 0, 0, 1, 9, 1, 1);
        cycle(1, 9, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("byp_idx9", 32'(lookup_cnt_o), 32'd2);
        idle(3);
        cycle(1, 9, 0, 0, 1, 9, 0, 0);
        cycle(1, 9, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("byp_idx9_var", 32'(lookup_cnt_o), BYP ? 32'd0 : 32'd2);
        idle(3);

        // Reset with the queue non-empty, then confirm pending writes are lost.
        cycle(1, 0, 0, 0, 1, 40, 3, 1);
        cycle(1, 0, 0, 0, 1, 41, 3, 1);
        do_reset();
        idle(64);
        chk("busy_len_run_rst", 32'(busy_seen), 32'd64);
        cycle(1, 40, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("lost_upd_40", 32'(lookup_cnt_o), 32'd2);

        // Reset in the middle of INIT at entry 30.
        do_reset();
        idle(30);
        do_reset();
        idle(70);
        chk("busy_len_init_rst", 32'(busy_seen), 32'd64);

        // Random traffic over a small index range to force collisions.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cycle(($urandom_range(0, 9) < 6), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 7), $urandom_range(0, 3),
                  1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pu_or1k_branch_predictor_table_ctrl.md
# pu_or1k_branch_predictor_table_ctrl

Controller for a table of 2-bit saturation counters (bimodal branch predictor) shared between the decode-stage lookup port and the execute-stage update port. It sits between the fetch/decode pipeline and a single-ported counter RAM. It initialises every entry after reset and buffers updates in a small queue. Lookups are arbitrated against queued writes so that the RAM sees at most one access per cycle.

## Interface
- `INDEX_WIDTH`, 6, table index width; the table holds 2^INDEX_WIDTH entries.
- `UPDQ_DEPTH`, 2, update-queue depth; must be a power of two and at least 2.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset: one clock, asynchronous, active-low.
- `lookup_valid_i`  in  1  lookup request.
- `lookup_ready_o`  out  1  lookup accepted this cycle when high together with `lookup_valid_i`.
- `lookup_index_i`  in  INDEX_WIDTH  table index of the branch being predicted.
- `lookup_op_bf_i`  in  1  instruction being predicted is `l.bf`.
- `lookup_op_bnf_i`  in  1  instruction being predicted is `l.bnf`.
- `lookup_cnt_o`  out  2  counter value returned for the accepted lookup.
- `predicted_flag_o`  out  1  `(cnt[1] && bf_q) || (!cnt[1] && bnf_q)`.
- `upd_valid_i`  in  1  update request.
- `upd_ready_o`  out  1  the update queue can accept an entry.
- `upd_index_i`  in  INDEX_WIDTH  table index of the resolved branch.
- `upd_cnt_i`  in  2  counter value that the branch's lookup returned.
- `upd_taken_i`  in  1  branch outcome.
- `busy_o`  out  1  table initialisation in progress.

## Operation
- FSM states: INIT and RUN. Reset enters INIT with the init pointer at 0.
- INIT behaviour:
  - Write 2'b10 (weakly taken) to entry `ptr` each cycle and increment `ptr`.
  - After the write to entry 2^INDEX_WIDTH−1, go to RUN.
  - `busy_o` is 1 throughout INIT.
  - `lookup_ready_o` is 1; lookups return 2'b10 with no RAM read.
  - `upd_ready_o` is 0.
- RUN, update accept:
  - An update is accepted when `upd_valid_i && upd_ready_o`.
  - The next counter value is computed at accept:
    - taken: 00→01→10→11→11.
    - not taken: 11→10→01→00→00.
  - `{index, next}` is pushed to the queue.
  - `upd_ready_o = !full`.
- RUN, RAM arbitration (one access per cycle):
  - Queue full: drain the head (RAM write) and hold `lookup_ready_o`=0.
  - Otherwise, when `lookup_valid_i`=1: do the lookup read and set `lookup_ready_o`=1. No drain.
  - Otherwise, when the queue is not empty: drain the head.
- A push and a drain in the same cycle are legal; the occupancy stays unchanged.
- Lookup data:
  - `lookup_cnt_o`, `predicted_flag_o`, `bf_q` and `bnf_q` hold their last value until the next accepted lookup.
  - An update accepted in the same cycle as a lookup is never visible to that lookup.
- Reset values: `lookup_cnt_o`=2'b10, `predicted_flag_o`=0, `lookup_ready_o`=1, `upd_ready_o`=0, `busy_o`=1. The queue is empty.
- Reset mid-operation: the queue is flushed, pending updates are lost, and INIT restarts from entry 0.

## Timing
- Lookup latency is 1 cycle: accepted in cycle N, the result is valid from cycle N+1.
- Update-to-RAM latency is at least 1 cycle after accept. It is unbounded while lookups are continuous, until the queue fills; at most UPDQ_DEPTH lookups are then blocked in a row.
- INIT takes exactly 2^INDEX_WIDTH cycles after `rst_n` deasserts. `busy_o` falls at the edge that completes the last write, and `upd_ready_o` rises at that same edge.
- All outputs are registered except `lookup_ready_o`, which is combinational from queue-full.

## Configuration
- `PU_OR1K_BP_BYPASS_EN` defined:
  - An accepted lookup whose index matches a valid queue entry returns the youngest matching entry's counter instead of RAM data.
  - The RAM read result is discarded for that lookup.
- `PU_OR1K_BP_BYPASS_EN` undefined: lookups always return RAM contents, which may be stale by up to UPDQ_DEPTH updates.

## Structure
- Package `pu_or1k_bp_pkg` holds:
  - the counter constants STRONGLY_NOT_TAKEN=00, WEAKLY_NOT_TAKEN=01, WEAKLY_TAKEN=10, STRONGLY_TAKEN=11;
  - the FSM state enum;
  - a `sat_next(cnt, taken)` function.
- One sub-module, `pu_or1k_bp_counter_ram`: a single port with a synchronous 1-cycle read, a write enable, and no reset on its contents.
- The queue, the FSM and the bypass logic stay inline.

## Test plan
- Reset, then 64 idle cycles with INDEX_WIDTH=6:
  - `busy_o`=1 for exactly 64 cycles;
  - afterwards, a lookup at every index returns 2'b10.
- Three taken updates to index 5, then a lookup at index 5:
  - after the drains, `lookup_cnt_o`=11;
  - with `lookup_op_bf_i`=1, `predicted_flag_o`=1.
- Continuous `lookup_valid_i` while two updates are pushed:
  - `lookup_ready_o`=0 for exactly one cycle while the queue is full;
  - the head drains and `upd_ready_o` returns to 1.
- Bypass build, with an update pushed to index 9 (cnt 01, taken) and an immediate lookup at 9 before the drain:
  - `lookup_cnt_o`=10.
  - Without the macro, the same stimulus returns the old RAM value 10; then run the variant with `upd_cnt_i`=00, which must return 00.
- Assert `rst_n` at INIT entry 30 and with the queue non-empty in RUN:
  - the queue empties;
  - `busy_o`=1;
  - INIT restarts from entry 0 and takes the full 64 cycles.
